// File: rtl/morse_compose_pkg.sv
// Shared morse symbol codes, word geometry and compose FSM encoding.
package morse_compose_pkg;
  localparam logic [1:0] MORSE_DOT    = 2'b10;
  localparam logic [1:0] MORSE_DASH   = 2'b11;
  localparam int         MORSE_WIDTH  = 10;
  localparam int         MORSE_MAXSYM = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2
  } mc_state_e;

  // Slot k occupies bits [9-2k:8-2k]; symbol 0 is leftmost.
  function automatic logic [MORSE_WIDTH-1:0] morse_put(input logic [MORSE_WIDTH-1:0] w,
                                                       input logic [2:0] k,
                                                       input logic [1:0] code);
    logic [MORSE_WIDTH-1:0] r;
    r = w;
    for (int i = 0; i < MORSE_MAXSYM; i++)
      if (k == 3'(i)) r[MORSE_WIDTH-1-2*i -: 2] = code;
    return r;
  endfunction
endpackage

// File: rtl/morse_compose_tick_gen.sv
// Symbol-tick prescaler: one-cycle strobe every TICK_DIV clocks.
module tick_gen #(
  parameter int TICK_DIV = 25000000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset)     cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/morse_compose.sv
// Morse key decoder: times presses against the symbol tick and emits 10-bit words.
// Define MORSE_COMPOSE_SYNC_EN to pass key through a 2-flop synchronizer.
module morse_compose
  import morse_compose_pkg::*;
#(
  parameter int TICK_DIV  = 25000000,
  parameter int GAP_TICKS = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   key,
  output logic [MORSE_WIDTH-1:0] morse,
  output logic [2:0]             nsym,
  output logic                   valid,
  output logic                   tick
);
  localparam int GW = $clog2(GAP_TICKS + 1);

  mc_state_e              state, state_n;
  logic [1:0]             len;
  logic [GW-1:0]          gap, gap_inc;
  logic [2:0]             symcnt, cnt_inc;
  logic [MORSE_WIDTH-1:0] sbuf, buf_ins;
  logic [1:0]             sym_code;
  logic                   ks, release_t, full, gap_done, emit_full, emit_gap;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

`ifdef MORSE_COMPOSE_SYNC_EN
  logic key_s1, key_s2;
  always_ff @(posedge clk) begin
    if (reset) begin
      key_s1 <= 1'b0;
      key_s2 <= 1'b0;
    end else begin
      key_s1 <= key;
      key_s2 <= key_s1;
    end
  end
  assign ks = key_s2;
`else
  assign ks = key;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (tick) begin
      case (state)
        IDLE:    if (ks) state_n = PRESS;
        PRESS:   if (!ks) state_n = full ? IDLE : GAP;
        GAP:     if (ks) state_n = PRESS;
                 else if (gap_done) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_comb begin
    sym_code  = (len == 2'd1) ? MORSE_DOT : MORSE_DASH;
    buf_ins   = morse_put(sbuf, symcnt, sym_code);
    cnt_inc   = symcnt + 3'd1;
    gap_inc   = gap + 1'b1;
    full      = (cnt_inc == 3'(MORSE_MAXSYM));
    gap_done  = (gap_inc == GW'(GAP_TICKS));
    release_t = tick && !ks;
    emit_full = release_t && (state == PRESS) && full;
    emit_gap  = release_t && (state == GAP) && gap_done;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len    <= '0;
      gap    <= '0;
      symcnt <= '0;
      sbuf   <= '0;
      morse  <= '0;
      nsym   <= '0;
      valid  <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (emit_full || emit_gap) begin
        morse  <= emit_full ? buf_ins : sbuf;
        nsym   <= emit_full ? cnt_inc : symcnt;
        valid  <= 1'b1;
        sbuf   <= '0;
        symcnt <= '0;
        gap    <= '0;
      end else if (tick) begin
        case (state)
          IDLE:  if (ks) len <= 2'd1;
          PRESS: begin
            if (ks) begin
              if (len != 2'd3) len <= len + 2'd1;
            end else begin
              sbuf   <= buf_ins;
              symcnt <= cnt_inc;
              gap    <= GW'(1);
            end
          end
          GAP: begin
            if (ks) len <= 2'd1;
            else    gap <= gap_inc;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_morse_compose.sv
// Bench for morse_compose: directed letter table plus random keying vs a tick-level model.
module tb_morse_compose;
  localparam int TD  = 4;
  localparam int GAP = 3;

  logic       clk = 1'b0;
  logic       reset, key;
  logic [9:0] morse;
  logic [2:0] nsym;
  logic       valid, tick;

  morse_compose #(.TICK_DIV(TD), .GAP_TICKS(GAP)) dut (
    .clk   (clk),
    .reset (reset),
    .key   (key),
    .morse (morse),
    .nsym  (nsym),
    .valid (valid),
    .tick  (tick)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0, nval = 0;
  bit chk = 0;

  // Reference: unsaturated press/gap lengths in ticks, symbols kept in a queue.
  int         pc = 0, press = 0, gapn = 0;
  logic [1:0] syms[$];
  bit         ev = 0;
  logic [9:0] em = '0;
  int         en = 0;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_emit();
    em = '0;
    foreach (syms[i]) em = em | ({8'b0, syms[i]} << (8 - 2*i));
    en = syms.size();
    ev = 1;
    syms.delete();
    gapn = 0;
  endtask

  task automatic model_tick(input bit k);
    if (press > 0) begin
      if (k) press++;
      else begin
        syms.push_back(press == 1 ? 2'b10 : 2'b11);
        press = 0;
        if (syms.size() == 5) model_emit();
        else gapn = 1;
      end
    end else if (syms.size() > 0) begin
      if (k) press = 1;
      else begin
        gapn++;
        if (gapn == GAP) model_emit();
      end
    end else if (k) press = 1;
  endtask

  task automatic cycle();
    if (chk) begin
      check("tick", int'(tick), int'(pc == TD-1));
      check("valid", int'(valid), int'(ev));
      check("morse", int'(morse), int'(em));
      check("nsym", int'(nsym), en);
      if (valid === 1'b1) nval++;
    end
    if (reset) begin
      pc = 0; press = 0; gapn = 0; syms.delete();
      ev = 0; em = '0; en = 0;
    end else begin
      ev = 0;
      if (pc == TD-1) begin
        model_tick(key);
        pc = 0;
      end else pc++;
    end
    @(posedge clk);
    @(negedge clk);
    chk = 1;
  endtask

  task automatic do_tick(input bit k);
    key = k;
    repeat (TD) cycle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    key   = 1'b0;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  typedef struct {
    logic [63:0] pat;
    int          plen;
    logic [9:0]  m;
    int          n;
    int          nv;
  } vec_t;

  vec_t vt[6];

  initial begin
    logic [63:0] p;
    reset = 1'b1;
    key   = 1'b0;
    @(negedge clk);

    // Key pattern is read left to right, one bit per tick.
    vt[0] = '{64'b1000,              4, 10'b1000000000, 1, 1};
    vt[1] = '{64'b1011000,           7, 10'b1011000000, 2, 1};
    vt[2] = '{64'b110110110110110,  15, 10'b1111111111, 5, 1};
    vt[3] = '{64'b1111111111000,    13, 10'b1100000000, 1, 1};
    vt[4] = '{64'b10101010101000,   14, 10'b1000000000, 1, 2};
    vt[5] = '{64'b1001000,           7, 10'b1010000000, 2, 1};

    do_reset();
    check("reset_valid", int'(valid), 0);
    check("reset_morse", int'(morse), 0);
    check("reset_nsym", int'(nsym), 0);

    for (int v = 0; v < 6; v++) begin
      do_reset();
      nval = 0;
      p = vt[v].pat;
      for (int i = 0; i < vt[v].plen; i++) do_tick(p[vt[v].plen-1-i]);
      do_tick(1'b0);
      do_tick(1'b0);
      check($sformatf("vec%0d_nvalid", v), nval, vt[v].nv);
      check($sformatf("vec%0d_morse", v), int'(morse), int'(vt[v].m));
      check($sformatf("vec%0d_nsym", v), int'(nsym), vt[v].n);
    end

    // Reset in the middle of a gap drops the pending dot.
    do_reset();
    nval = 0;
    do_tick(1'b1);
    do_tick(1'b0);
    key = 1'b0;
    cycle();
    cycle();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    do_tick(1'b1);
    do_tick(1'b1);
    repeat (5) do_tick(1'b0);
    check("midreset_nvalid", nval, 1);
    check("midreset_morse", int'(morse), 10'b1100000000);
    check("midreset_nsym", int'(nsym), 1);

    do_reset();
    nval = 0;
    repeat (50) do_tick(1'b0);
    check("idle_nvalid", nval, 0);
    check("idle_morse", int'(morse), 0);

    do_reset();
    nval = 0;
    for (int i = 0; i < 300; i++) do_tick($urandom_range(0, 99) < 45);
    repeat (5) do_tick(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
